mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit, directly downstream of the decode controller.
- Consumes the M-stage control it produces (memread_M_true, memwrite_M_true, load_store_M) plus the ALU address and store data.
- Runs a multi-cycle request/acknowledge transaction to the data memory/cache and asserts miss to stall the pipeline until the access completes.
- Returns the byte/half/word-extracted, sign- or zero-extended load result to writeback.

Parameters:
- DATA_WIDTH, 32, data path width; only 32 is supported.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- memread_M  in  1  M-stage load valid.
- memwrite_M  in  1  M-stage store valid.
- load_store_M  in  3  access type: 000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw, 101 sb, 110 sh, 111 sw.
- addr_M  in  ADDR_WIDTH  byte address (ALU result).
- wdata_M  in  DATA_WIDTH  store data (rs2).
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00}), registered.
- mem_wstrb  out  4  byte write strobes, registered.
- mem_wdata  out  DATA_WIDTH  lane-replicated store data, registered.
- mem_ack  in  1  memory completion, one cycle wide.
- mem_rdata  in  DATA_WIDTH  read word, valid with mem_ack.
- miss  out  1  pipeline stall request.
- misalign  out  1  misaligned-access flag, combinational.
- rdata_M  out  DATA_WIDTH  formatted load result, registered.

Behaviour:
- Reset values:
  - state = IDLE.
  - mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata = 0.
  - rdata_M = 0.
  - miss and misalign are combinational; both evaluate to 0 in IDLE with no access.
- access = memread_M | memwrite_M.
- is_store = memwrite_M & load_store_M[2] & (load_store_M[1:0] != 00).
- Misalignment:
  - lh/lhu/sh with addr[0] = 1.
  - lw/sw with addr[1:0] != 00.
  - misalign = access & misaligned, and is asserted only in IDLE.
- States: IDLE, WAIT, DONE.
- IDLE:
  - If access & ~misalign: miss = 1 in this same cycle. On the edge, latch the request (mem_req = 1, mem_we = is_store, mem_addr, mem_wstrb, mem_wdata) and go to WAIT.
  - If access & misalign: no request, miss = 0, rdata_M unchanged, stay in IDLE. The pipeline advances, and misalign is consumed elsewhere as an exception.
- WAIT:
  - miss = 1.
  - mem_req and all request fields are held stable until mem_ack.
  - On mem_ack, clear mem_req on the edge and go to DONE.
  - If the access was a load, also register the formatted mem_rdata into rdata_M on that edge.
  - The earliest mem_ack is the first WAIT cycle.
- DONE:
  - miss = 0, so the pipeline advances the M instruction this cycle.
  - Go unconditionally to IDLE, which guarantees that the same instruction is never re-issued.
- Latency: minimum 2 stalled cycles (IDLE + 1 WAIT) plus the DONE cycle; each extra memory wait cycle adds one stalled cycle.
- Store lanes, with b = addr[1:0]:
  - sb: wstrb = 0001<<b, wdata = {4{wdata_M[7:0]}}.
  - sh: wstrb = 0011<<{b[1],0}, wdata = {2{wdata_M[15:0]}}.
  - sw: wstrb = 1111, wdata = wdata_M.
- Load format:
  - Select byte mem_rdata[8b+7:8b], or half mem_rdata[16b[1]+15:16b[1]].
  - lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
  - Offsets are taken from the latched address, not the live addr_M.
- Stores leave rdata_M unchanged. rdata_M holds its value until the next load completes.
- Illegal combinations:
  - memwrite_M with a load code is treated as a read with mem_we = 0.
  - memread_M with a store code performs the access as a read with word lanes (wstrb = 0) and formats rdata_M as lw.
- mem_ack outside WAIT is ignored.
- rst asserted mid-transaction: immediate return to IDLE, mem_req drops asynchronously, and any later ack is ignored.
- There is no flush input: the pipeline holds the M instruction stable while miss = 1.

Test Plan:
- lw at addr 0x100, mem_rdata = 0xDEADBEEF, ack on the 3rd WAIT cycle:
  - miss high for 4 cycles.
  - mem_addr = 0x100, mem_we = 0.
  - rdata_M = 0xDEADBEEF in DONE.
- lb / lbu at addr 0x103, mem_rdata = 0x80FF7F01:
  - lb gives rdata_M = 0xFFFFFF80; lbu gives 0x00000080.
  - lh at 0x102 gives 0xFFFF80FF.
- sb at 0x101 with wdata_M = 0x12345678: mem_wstrb = 0010, mem_wdata = 0x78787878, mem_we = 1, rdata_M unchanged.
- sh at 0x102 with wdata_M = 0xAAAA5555: mem_wstrb = 1100, mem_wdata = 0x55555555.
- lw at 0x102 (misaligned): misalign = 1, miss = 0, mem_req never asserted, state stays IDLE.
- rst pulsed in WAIT: mem_req = 0 immediately; a later mem_ack = 1 causes no rdata_M change and no miss. A back-to-back lw then sw each produce exactly one request.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit.
// Issues one request/acknowledge transaction per M-stage access and holds
// the pipeline with miss until the access completes. Load data is extracted
// from the returned word and sign/zero-extended into rdata_M.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   memread_M, memwrite_M M-stage load / store valid
//   load_store_M          access type (lb,lbu,lh,lhu,lw,sb,sh,sw)
//   addr_M, wdata_M       byte address and store data
//   mem_req/we/addr/wstrb/wdata   registered memory request
//   mem_ack, mem_rdata    one-cycle completion and read word
//   miss                  stall request (combinational)
//   misalign              misaligned-access flag (combinational, IDLE only)
//   rdata_M               formatted load result (registered)
module mem_stage_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memread_M,
  input  logic                  memwrite_M,
  input  logic [2:0]            load_store_M,
  input  logic [ADDR_WIDTH-1:0] addr_M,
  input  logic [DATA_WIDTH-1:0] wdata_M,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  miss,
  output logic                  misalign,
  output logic [DATA_WIDTH-1:0] rdata_M
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [2:0]            fmt_q, fmt_d;   // load format code of the access in flight
  logic [1:0]            off_q, off_d;   // byte offset of the access in flight

  logic                  access_s;
  logic                  is_store_s;
  logic                  misaligned_s;
  logic [3:0]            lane_strb_s;
  logic [DATA_WIDTH-1:0] lane_wdata_s;

  // Extract and extend the addressed byte/half; anything not lb/lbu/lh/lhu is a word.
  function automatic logic [DATA_WIDTH-1:0] fmt_load(input logic [2:0] fmt,
                                                     input logic [1:0] off,
                                                     input logic [DATA_WIDTH-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (fmt)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {24'h00_0000, b};
      3'b010:  fmt_load = {{16{h[15]}}, h};
      3'b011:  fmt_load = {16'h0000, h};
      default: fmt_load = word;
    endcase
  endfunction

  assign access_s   = memread_M | memwrite_M;
  assign is_store_s = memwrite_M & load_store_M[2] & (load_store_M[1:0] != 2'b00);

  // Alignment check by access code (applies to reads issued with store codes too).
  always_comb begin
    misaligned_s = 1'b0;
    case (load_store_M)
      3'b010, 3'b011, 3'b110: misaligned_s = addr_M[0];
      3'b100, 3'b111:         misaligned_s = (addr_M[1:0] != 2'b00);
      default:                misaligned_s = 1'b0;
    endcase
  end

  // Store byte lanes and replicated data; reads carry no strobes.
  always_comb begin
    lane_strb_s  = 4'b0000;
    lane_wdata_s = {DATA_WIDTH{1'b0}};
    if (is_store_s) begin
      case (load_store_M[1:0])
        2'b01: begin
          lane_strb_s  = 4'b0001 << addr_M[1:0];
          lane_wdata_s = {4{wdata_M[7:0]}};
        end
        2'b10: begin
          lane_strb_s  = addr_M[1] ? 4'b1100 : 4'b0011;
          lane_wdata_s = {2{wdata_M[15:0]}};
        end
        default: begin
          lane_strb_s  = 4'b1111;
          lane_wdata_s = wdata_M;
        end
      endcase
    end else begin
      lane_strb_s  = 4'b0000;
      lane_wdata_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Next-state and stall logic of the request FSM.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fmt_d   = fmt_q;
    off_d   = off_q;
    miss    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access_s & ~misaligned_s) begin
          miss    = 1'b1;
          state_d = ST_WAIT;
          req_d   = 1'b1;
          we_d    = is_store_s;
          addr_d  = {addr_M[ADDR_WIDTH-1:2], 2'b00};
          wstrb_d = lane_strb_s;
          wdata_d = lane_wdata_s;
          // A read issued with a store code is formatted as a full word.
          fmt_d   = load_store_M[2] ? 3'b100 : load_store_M;
          off_d   = addr_M[1:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        miss = 1'b1;
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = fmt_load(fmt_q, off_q, mem_rdata);
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and request register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      wstrb_q <= 4'b0000;
      wdata_q <= {DATA_WIDTH{1'b0}};
      rdata_q <= {DATA_WIDTH{1'b0}};
      fmt_q   <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fmt_q   <= fmt_d;
      off_q   <= off_d;
    end
  end

  assign misalign  = (state_q == ST_IDLE) & access_s & misaligned_s;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;
  assign rdata_M   = rdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: inputs are driven on the falling edge,
// outputs sampled on the falling edge (or #1 after driving for combinational
// outputs), with hand-computed expectations.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic        memread_M;
  logic        memwrite_M;
  logic [2:0]  load_store_M;
  logic [31:0] addr_M;
  logic [31:0] wdata_M;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        miss;
  logic        misalign;
  logic [31:0] rdata_M;

  int checks;
  int errors;
  int req_cnt;

  mem_stage_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .memread_M    (memread_M),
    .memwrite_M   (memwrite_M),
    .load_store_M (load_store_M),
    .addr_M       (addr_M),
    .wdata_M      (wdata_M),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .miss         (miss),
    .misalign     (misalign),
    .rdata_M      (rdata_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count issued memory requests.
  always @(posedge mem_req) req_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Run one aligned access starting at a falling edge in IDLE; ends in IDLE.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] ls, input logic [31:0] addr,
                            input logic [31:0] wd, input int ack_wait,
                            input logic [31:0] rword, input logic exp_we,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_rdata);
    int misses;
    misses = 0;
    memread_M = rd; memwrite_M = wr; load_store_M = ls; addr_M = addr; wdata_M = wd;
    #1;
    if (miss) misses++;
    check_eq({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
    @(posedge clk); @(negedge clk);
    check_eq({tag, "_req"},   {31'd0, mem_req}, 32'd1);
    check_eq({tag, "_we"},    {31'd0, mem_we}, {31'd0, exp_we});
    check_eq({tag, "_addr"},  mem_addr, {addr[31:2], 2'b00});
    check_eq({tag, "_wstrb"}, {28'd0, mem_wstrb}, {28'd0, exp_strb});
    if (exp_we) check_eq({tag, "_wdata"}, mem_wdata, exp_wdata);
    for (int k = 1; k <= ack_wait; k++) begin
      if (miss) misses++;
      if (k == ack_wait) begin
        check_eq({tag, "_req_held"}, {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        mem_rdata = rword;
      end
      @(posedge clk); @(negedge clk);
      mem_ack = 1'b0;
    end
    check_eq({tag, "_done_miss"}, {31'd0, miss}, 32'd0);
    check_eq({tag, "_done_req"},  {31'd0, mem_req}, 32'd0);
    check_eq({tag, "_rdata"},     rdata_M, exp_rdata);
    check_eq({tag, "_stall_cycles"}, misses, ack_wait + 1);
    memread_M = 1'b0; memwrite_M = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq({tag, "_idle_req"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; req_cnt = 0;
    rst = 1'b1;
    memread_M = 1'b0; memwrite_M = 1'b0; load_store_M = 3'b000;
    addr_M = 32'd0; wdata_M = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    @(negedge clk); @(negedge clk);
    check_eq("rst_req",      {31'd0, mem_req}, 32'd0);
    check_eq("rst_we",       {31'd0, mem_we}, 32'd0);
    check_eq("rst_addr",     mem_addr, 32'd0);
    check_eq("rst_wstrb",    {28'd0, mem_wstrb}, 32'd0);
    check_eq("rst_wdata",    mem_wdata, 32'd0);
    check_eq("rst_rdata",    rdata_M, 32'd0);
    check_eq("rst_miss",     {31'd0, miss}, 32'd0);
    check_eq("rst_misalign", {31'd0, misalign}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Loads: word with three wait cycles, then byte/half extraction.
    run_access("lw100",  1'b1, 1'b0, 3'b100, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b0, 4'b0000, 32'h0, 32'hDEADBEEF);
    run_access("lb103",  1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF7F01, 1'b0, 4'b0000, 32'h0, 32'hFFFFFF80);
    run_access("lbu103", 1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 2, 32'h80FF7F01, 1'b0, 4'b0000, 32'h0, 32'h00000080);
    run_access("lh102",  1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 1, 32'h80FF7F01, 1'b0, 4'b0000, 32'h0, 32'hFFFF80FF);
    run_access("lhu102", 1'b1, 1'b0, 3'b011, 32'h102, 32'h0, 1, 32'h80FF7F01, 1'b0, 4'b0000, 32'h0, 32'h000080FF);
    run_access("lb100",  1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 1, 32'h80FF7F01, 1'b0, 4'b0000, 32'h0, 32'h00000001);

    // Stores leave rdata_M at the last load value (0x00000001).
    run_access("sb101", 1'b0, 1'b1, 3'b101, 32'h101, 32'h12345678, 1, 32'h0BADF00D, 1'b1, 4'b0010, 32'h78787878, 32'h00000001);
    run_access("sh102", 1'b0, 1'b1, 3'b110, 32'h102, 32'hAAAA5555, 2, 32'h0BADF00D, 1'b1, 4'b1100, 32'h55555555, 32'h00000001);
    run_access("sw104", 1'b0, 1'b1, 3'b111, 32'h104, 32'hCAFEF00D, 1, 32'h0BADF00D, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h00000001);

    // Illegal combinations: read with store code -> word read; write with load code -> read.
    run_access("rd_swcode", 1'b1, 1'b0, 3'b111, 32'h108, 32'h0, 1, 32'h13572468, 1'b0, 4'b0000, 32'h0, 32'h13572468);
    run_access("wr_lbucode", 1'b0, 1'b1, 3'b001, 32'h10A, 32'hFFFFFFFF, 1, 32'h00C30000, 1'b0, 4'b0000, 32'h0, 32'h000000C3);

    // Misaligned word load: flag only, no request, stays in IDLE.
    req_cnt = 0;
    memread_M = 1'b1; load_store_M = 3'b100; addr_M = 32'h102;
    #1;
    check_eq("mis_lw_flag", {31'd0, misalign}, 32'd1);
    check_eq("mis_lw_miss", {31'd0, miss}, 32'd0);
    @(posedge clk); @(negedge clk);
    check_eq("mis_lw_req",   {31'd0, mem_req}, 32'd0);
    check_eq("mis_lw_idle",  {31'd0, misalign}, 32'd1);
    load_store_M = 3'b010; addr_M = 32'h101;
    #1;
    check_eq("mis_lh_flag", {31'd0, misalign}, 32'd1);
    memread_M = 1'b0;
    #1;
    check_eq("mis_clear", {31'd0, misalign}, 32'd0);
    check_eq("mis_reqcnt", req_cnt, 32'd0);
    @(negedge clk);

    // Stray ack in IDLE is ignored.
    mem_ack = 1'b1; mem_rdata = 32'h99999999;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    check_eq("stray_ack_rdata", rdata_M, 32'h000000C3);
    check_eq("stray_ack_req",   {31'd0, mem_req}, 32'd0);

    // Reset while waiting: request drops immediately, late ack ignored.
    memread_M = 1'b1; load_store_M = 3'b100; addr_M = 32'h200;
    @(posedge clk); @(negedge clk);
    check_eq("rstw_req_before", {31'd0, mem_req}, 32'd1);
    memread_M = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rstw_req_async", {31'd0, mem_req}, 32'd0);
    check_eq("rstw_miss",      {31'd0, miss}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    check_eq("rstw_late_rdata", rdata_M, 32'h0);
    check_eq("rstw_late_miss",  {31'd0, miss}, 32'd0);
    check_eq("rstw_late_req",   {31'd0, mem_req}, 32'd0);

    // Back-to-back lw then sw: exactly one request each.
    req_cnt = 0;
    run_access("b2b_lw", 1'b1, 1'b0, 3'b100, 32'h300, 32'h0, 1, 32'h01234567, 1'b0, 4'b0000, 32'h0, 32'h01234567);
    run_access("b2b_sw", 1'b0, 1'b1, 3'b111, 32'h304, 32'h89ABCDEF, 1, 32'h0, 1'b1, 4'b1111, 32'h89ABCDEF, 32'h01234567);
    @(posedge clk); @(negedge clk);
    check_eq("b2b_reqcnt", req_cnt, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
